pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
- Parametrised pipeline stage register, the successor to the fixed IF/ID latch.
- Carries an arbitrary packed payload (default {prediction, PC, instruction}) with a valid/ready handshake, synchronous flush and bubble injection.
- Optional 2-entry skid buffer, so that in_ready is registered and timing is broken between stages.
- Instantiated between IF/ID, ID/EX, EX/MEM and MEM/WB. A hazard unit drives out_ready (stall) and flush (branch mispredict).

Parameters:
- DATA_W, 65: payload width in bits. Default packs {pred[64], pc[63:32], instr[31:0]}.
- BUBBLE, 65'h13: payload presented when the stage is empty or flushed. Default is addi x0,x0,0 with pc=0 and pred=0.
- SKID, 1: 1 = two-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready.
- CNT_W, 16: width of the saturating stall counter.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- flush  in  1  discard all held entries this cycle
- in_valid  in  1  upstream has a payload
- in_ready  out  1  stage can accept a payload
- in_data  in  DATA_W  upstream payload
- out_valid  out  1  out_data holds a real payload
- out_ready  in  1  downstream accepts (0 = stall)
- out_data  out  DATA_W  payload to next stage; equals BUBBLE when out_valid=0
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating

Behaviour:
- Interface (already decided): one clock; reset is synchronous and active-high. Clock port is clk, reset port is reset.
- Handshake definitions: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Reset, sampled at posedge clk:
  - out_valid=0, out_data=BUBBLE, skid_valid=0, stall_cnt=0.
  - in_ready=1 from the first cycle after reset.
  - Reset asserted mid-transfer drops every held payload; none is emitted.
- Priority order: reset > flush > normal operation.
- flush=1:
  - Next cycle: out_valid=0, out_data=BUBBLE, skid emptied, in_ready=1.
  - A payload offered in the same cycle is discarded even if in_fire=1.
  - stall_cnt is not affected.
- SKID=1, states EMPTY / ONE / FULL:
  - in_ready = !skid_valid, driven from a register.
  - EMPTY: in_fire -> main<=in_data, go to ONE.
  - ONE, in_fire & out_fire: main<=in_data, stay in ONE (full throughput, 1 payload/cycle).
  - ONE, in_fire & !out_fire: skid<=in_data, go to FULL, in_ready=0 next cycle.
  - ONE, !in_fire & out_fire: go to EMPTY, out_data<=BUBBLE.
  - FULL: no in_fire is possible. out_fire -> main<=skid, go to ONE, in_ready=1 next cycle.
  - Ordering is strictly FIFO: the skid entry is always older than any new input.
- SKID=0, single register:
  - in_ready = out_ready | !out_valid (combinational).
  - in_fire loads main. Otherwise out_fire empties main to BUBBLE.
- Latency: exactly 1 cycle from in_fire to out_valid when the stage was empty or draining.
- out_data must never change while out_valid=1 and out_ready=0. Payload stability under stall is mandatory.
- When out_valid=0, out_data=BUBBLE, so downstream decoders see a NOP.
- stall_cnt increments by 1 per cycle with out_valid & !out_ready. It saturates at 2^CNT_W-1, with no wrap, and is cleared only by reset.
- No X propagation: all registers get explicit reset values, including the skid payload (BUBBLE).

Decomposition:
- Shared package riscv_pipe_pkg holds:
  - localparams INSTR_W=32, PC_W=32, NOP_INSTR=32'h0000_0013.
  - Packed struct if_id_t {pred, pc, instr} and its width constant.
  - Default BUBBLE value built from NOP_INSTR.
- One natural sub-module: sat_counter (CNT_W, inc, clear) for stall_cnt. The skid logic stays inline.

Test Plan:
- Reset then stream: reset=1 for 2 cycles, then in_data=0x13+{pc=0x4..0x20}, in_valid=1 continuously, out_ready=1 -> out_valid=1 from cycle 1, payloads out in order 1 cycle late, in_ready stays 1, stall_cnt=0.
- Stall fills skid (SKID=1): send A, B with out_ready=0 for 3 cycles -> out_data=A held stable, in_ready=0 after B, C held upstream, stall_cnt=3. Release -> A, B, C emitted back-to-back with no loss or duplication.
- Flush while FULL: main=A, skid=B, flush=1 with in_valid=1, in_data=C -> next cycle out_valid=0, out_data=65'h13, in_ready=1, C never emitted.
- Reset mid-stall: FULL, stall_cnt=5, reset=1 -> out_valid=0, stall_cnt=0, in_ready=1.
- Saturation: CNT_W=3, hold out_valid=1, out_ready=0 for 10 cycles -> stall_cnt reaches 7 and stays at 7.
- SKID=0 mode: out_ready toggling 1,0,1,0 with in_valid=1 -> in_ready tracks out_ready combinationally in the same cycle, order preserved, out_data stable while stalled.

Source files
------------

// File: rtl/riscv_pipe_pkg.sv
// rtl/riscv_pipe_pkg.sv - shared pipeline payload types, bubble value and stage states
package riscv_pipe_pkg;

  localparam int INSTR_W = 32;
  localparam int PC_W    = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic               pred;
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } if_id_t;

  localparam int IF_ID_W = $bits(if_id_t);

  // addi x0,x0,0 with pc=0 and no prediction
  localparam if_id_t IF_ID_BUBBLE = '{pred: 1'b0, pc: '0, instr: NOP_INSTR};

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_ONE,
    ST_FULL
  } stage_state_t;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (clear) begin
      count_q <= '0;
    end else if (inc && (count_q != '1)) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - pipeline stage register with valid/ready, flush and optional skid entry
module pipe_stage_reg
  import riscv_pipe_pkg::*;
#(
  parameter int                DATA_W = IF_ID_W,
  parameter logic [DATA_W-1:0] BUBBLE = DATA_W'(IF_ID_BUBBLE),
  parameter bit                SKID   = 1'b1,
  parameter int                CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  stage_state_t      state_q;
  logic [DATA_W-1:0] main_q;
  logic [DATA_W-1:0] skid_q;
  logic              out_valid_q;
  logic              in_ready_q;
  logic              in_fire;
  logic              out_fire;

  assign in_ready  = SKID ? in_ready_q : (out_ready | ~out_valid_q);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid_q & out_ready;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;

  // Without SKID, in_fire in ST_ONE implies out_fire, so ST_FULL is never entered.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      state_q     <= ST_EMPTY;
      out_valid_q <= 1'b0;
      main_q      <= BUBBLE;
      skid_q      <= BUBBLE;
      in_ready_q  <= 1'b1;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            main_q      <= in_data;
            out_valid_q <= 1'b1;
            state_q     <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (in_fire && !out_fire) begin
            skid_q     <= in_data;
            in_ready_q <= 1'b0;
            state_q    <= ST_FULL;
          end else if (in_fire) begin
            main_q <= in_data;
          end else if (out_fire) begin
            main_q      <= BUBBLE;
            out_valid_q <= 1'b0;
            state_q     <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (out_fire) begin
            main_q     <= skid_q;
            skid_q     <= BUBBLE;
            in_ready_q <= 1'b1;
            state_q    <= ST_ONE;
          end
        end
        default: state_q <= ST_EMPTY;
      endcase
    end
  end

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .clear(reset),
    .inc  (out_valid_q & ~out_ready),
    .count(stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - table-driven bench for pipe_stage_reg (skid, no-skid, saturating counter)
module tb_pipe_stage_reg;

  localparam logic [64:0] BUB = 65'h13;
  localparam logic [64:0] PA  = {1'b1, 32'h0000_0100, 32'h00a0_0093};
  localparam logic [64:0] PB  = {1'b0, 32'h0000_0104, 32'h0010_8113};
  localparam logic [64:0] PC  = {1'b1, 32'h0000_0108, 32'h0020_0193};
  localparam logic [64:0] PD  = {1'b0, 32'h0000_010c, 32'h0030_0213};

  typedef struct packed {
    logic        fl;
    logic        iv;
    logic        orr;
    logic [64:0] d;
    logic        eov;
    logic [64:0] eod;
    logic        eir;
    logic [15:0] esc;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic        flush = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic [64:0] in_data = '0;
  logic        in_ready, out_valid;
  logic [64:0] out_data;
  logic [15:0] stall_cnt;

  logic        s_in_ready, s_out_valid;
  logic [64:0] s_out_data;
  logic [2:0]  s_stall_cnt;

  logic        ns_flush = 1'b0, ns_in_valid = 1'b0, ns_out_ready = 1'b1;
  logic [64:0] ns_in_data = '0;
  logic        ns_in_ready, ns_out_valid;
  logic [64:0] ns_out_data;
  logic [15:0] ns_stall_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.SKID(1'b1), .CNT_W(16)) u_main (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .stall_cnt(stall_cnt));

  pipe_stage_reg #(.SKID(1'b1), .CNT_W(3)) u_sat (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_data(in_data), .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
    .stall_cnt(s_stall_cnt));

  pipe_stage_reg #(.SKID(1'b0), .CNT_W(16)) u_ns (
    .clk(clk), .reset(reset), .flush(ns_flush), .in_valid(ns_in_valid), .in_ready(ns_in_ready),
    .in_data(ns_in_data), .out_valid(ns_out_valid), .out_ready(ns_out_ready), .out_data(ns_out_data),
    .stall_cnt(ns_stall_cnt));

  task automatic chk(input string nm, input logic [64:0] act, input logic [64:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic fl, input logic iv, input logic orr, input logic [64:0] d,
                              input logic eov, input logic [64:0] eod, input logic eir,
                              input logic [15:0] esc);
    vec_t v;
    v.fl = fl; v.iv = iv; v.orr = orr; v.d = d;
    v.eov = eov; v.eod = eod; v.eir = eir; v.esc = esc;
    return v;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // drive one row, check outputs mid-cycle, then advance past the clock edge
  task automatic run_row(input vec_t v, input bit ns, input string tag);
    if (!ns) begin
      flush = v.fl; in_valid = v.iv; out_ready = v.orr; in_data = v.d;
    end else begin
      ns_flush = v.fl; ns_in_valid = v.iv; ns_out_ready = v.orr; ns_in_data = v.d;
    end
    @(negedge clk);
    if (!ns) begin
      chk({tag, ".out_valid"}, 65'(out_valid), 65'(v.eov));
      chk({tag, ".out_data"},  out_data, v.eod);
      chk({tag, ".in_ready"},  65'(in_ready), 65'(v.eir));
      chk({tag, ".stall_cnt"}, 65'(stall_cnt), 65'(v.esc));
    end else begin
      chk({tag, ".out_valid"}, 65'(ns_out_valid), 65'(v.eov));
      chk({tag, ".out_data"},  ns_out_data, v.eod);
      chk({tag, ".in_ready"},  65'(ns_in_ready), 65'(v.eir));
      chk({tag, ".stall_cnt"}, 65'(ns_stall_cnt), 65'(v.esc));
    end
    next_cycle();
  endtask

  vec_t tbl[14];
  vec_t ns_tbl[8];

  initial begin
    //            fl  iv  or  d    | ov  od   ir  sc
    tbl[0]  = mk(0, 1, 0, PA,  0, BUB, 1, 0);
    tbl[1]  = mk(0, 1, 0, PB,  1, PA,  1, 0);
    tbl[2]  = mk(0, 1, 0, PC,  1, PA,  0, 1);
    tbl[3]  = mk(0, 1, 0, PC,  1, PA,  0, 2);
    tbl[4]  = mk(0, 1, 1, PC,  1, PA,  0, 3);
    tbl[5]  = mk(0, 1, 1, PC,  1, PB,  1, 3);
    tbl[6]  = mk(0, 0, 1, BUB, 1, PC,  1, 3);
    tbl[7]  = mk(0, 0, 1, BUB, 0, BUB, 1, 3);
    tbl[8]  = mk(0, 1, 0, PA,  0, BUB, 1, 3);
    tbl[9]  = mk(0, 1, 0, PB,  1, PA,  1, 3);
    tbl[10] = mk(1, 1, 0, PC,  1, PA,  0, 4);
    tbl[11] = mk(0, 0, 1, BUB, 0, BUB, 1, 5);
    tbl[12] = mk(1, 1, 1, PD,  0, BUB, 1, 5);
    tbl[13] = mk(0, 0, 1, BUB, 0, BUB, 1, 5);

    ns_tbl[0] = mk(0, 1, 1, PA,  0, BUB, 1, 0);
    ns_tbl[1] = mk(0, 1, 0, PB,  1, PA,  0, 0);
    ns_tbl[2] = mk(0, 1, 1, PB,  1, PA,  1, 1);
    ns_tbl[3] = mk(0, 1, 0, PC,  1, PB,  0, 1);
    ns_tbl[4] = mk(0, 1, 1, PC,  1, PB,  1, 2);
    ns_tbl[5] = mk(0, 0, 0, BUB, 1, PC,  0, 2);
    ns_tbl[6] = mk(0, 0, 1, BUB, 1, PC,  1, 3);
    ns_tbl[7] = mk(0, 0, 1, BUB, 0, BUB, 1, 3);

    // reset for two cycles
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("reset.out_valid", 65'(out_valid), 65'(0));
    chk("reset.out_data",  out_data, BUB);
    chk("reset.in_ready",  65'(in_ready), 65'(1));
    chk("reset.stall_cnt", 65'(stall_cnt), 65'(0));
    next_cycle();

    // continuous stream of NOPs with pc 0x4..0x20
    for (int i = 0; i < 10; i++) begin
      logic [64:0] d, e;
      d = (i < 8) ? {1'b0, 32'(4 * (i + 1)), 32'h13} : BUB;
      e = (i >= 1 && i <= 8) ? {1'b0, 32'(4 * i), 32'h13} : BUB;
      run_row(mk(0, i < 8, 1, d, i >= 1 && i <= 8, e, 1, 0), 1'b0, $sformatf("stream%0d", i));
    end

    // skid fill/drain, flush while full, flush with in_fire
    for (int i = 0; i < 14; i++) begin
      run_row(tbl[i], 1'b0, $sformatf("skid%0d", i));
    end

    // clear counters, then hold a stall for ten cycles
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    run_row(mk(0, 1, 0, PA, 0, BUB, 1, 0), 1'b0, "sat_load");
    for (int k = 0; k < 11; k++) begin
      in_valid = (k == 0);
      in_data = PB;
      out_ready = 1'b0;
      @(negedge clk);
      chk($sformatf("sat%0d.out_data", k), out_data, PA);
      chk($sformatf("sat%0d.in_ready", k), 65'(in_ready), 65'(k == 0));
      chk($sformatf("sat%0d.stall_cnt", k), 65'(stall_cnt), 65'(k));
      chk($sformatf("sat%0d.sat_cnt", k), 65'(s_stall_cnt), 65'((k > 7) ? 7 : k));
      next_cycle();
    end

    // reset while full and stalled drops both payloads
    reset = 1'b1;
    in_valid = 1'b1;
    in_data = PC;
    out_ready = 1'b1;
    next_cycle();
    reset = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("rst_stall.out_valid", 65'(out_valid), 65'(0));
    chk("rst_stall.out_data",  out_data, BUB);
    chk("rst_stall.in_ready",  65'(in_ready), 65'(1));
    chk("rst_stall.stall_cnt", 65'(stall_cnt), 65'(0));
    chk("rst_stall.sat_cnt",   65'(s_stall_cnt), 65'(0));
    next_cycle();
    run_row(mk(0, 0, 1, BUB, 0, BUB, 1, 0), 1'b0, "rst_drop0");
    run_row(mk(0, 0, 1, BUB, 0, BUB, 1, 0), 1'b0, "rst_drop1");

    // single-register mode with toggling out_ready
    for (int i = 0; i < 8; i++) begin
      run_row(ns_tbl[i], 1'b1, $sformatf("noskid%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
